// File: rtl/bank_filter_pkg.sv
// bank_filter_pkg: shared types and constants for the bank filter controller and the tag-bank pair
package bank_filter_pkg;
  localparam int ADDR_WIDTH = 64;
  localparam logic SIDE_LEFT = 1'b0;
  localparam logic SIDE_RIGHT = 1'b1;
  typedef enum logic [1:0] {LOOKUP, INSERT, EMIT} state_e;
endpackage

// File: rtl/bank_filter_ctrl_if.sv
// bank_filter_ctrl_if: request, bank lookup/insert, filtered output and statistics signals
//   slave  : controller side (drives *_o, samples *_i)
//   master : environment side (upstream, the two banks, downstream)
interface bank_filter_ctrl_if import bank_filter_pkg::*; #(
  parameter int WIDTH = ADDR_WIDTH,
  parameter int CNT_WIDTH = 32
);
  logic req_valid_i;
  logic req_ready_o;
  logic [WIDTH-1:0] req_addr_i;
  logic lk_read_o;
  logic [WIDTH-1:0] lk_addr_o;
  logic left_hit_i;
  logic right_hit_i;
  logic left_write_o;
  logic right_write_o;
  logic [WIDTH-1:0] ins_data_o;
  logic out_valid_o;
  logic out_ready_i;
  logic [WIDTH-1:0] out_addr_o;
  logic [CNT_WIDTH-1:0] hit_count_o;
  logic [CNT_WIDTH-1:0] miss_count_o;
  modport slave (
    input req_valid_i, req_addr_i, left_hit_i, right_hit_i, out_ready_i,
    output req_ready_o, lk_read_o, lk_addr_o, left_write_o, right_write_o, ins_data_o,
    output out_valid_o, out_addr_o, hit_count_o, miss_count_o
  );
  modport master (
    output req_valid_i, req_addr_i, left_hit_i, right_hit_i, out_ready_i,
    input req_ready_o, lk_read_o, lk_addr_o, left_write_o, right_write_o, ins_data_o,
    input out_valid_o, out_addr_o, hit_count_o, miss_count_o
  );
endinterface

// File: rtl/bank_filter_ctrl_addr_fifo.sv
// addr_fifo: synchronous FIFO holding addresses waiting for a bank lookup
//   i_push/i_data enqueue, i_pop dequeues, o_head is the oldest entry, o_full/o_empty status
module addr_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic i_push,
  input  logic i_pop,
  input  logic [WIDTH-1:0] i_data,
  output logic o_full,
  output logic o_empty,
  output logic [WIDTH-1:0] o_head
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0] r_wr, r_rd;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      if (i_push) r_wr <= r_wr + 1'b1;
      if (i_pop) r_rd <= r_rd + 1'b1;
    end
  end
  always_ff @(posedge clk) if (i_push) r_mem[r_wr[AW-1:0]] <= i_data;
  // the extra pointer bit tells a full ring apart from an empty one
  assign o_empty = r_wr == r_rd;
  assign o_full = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
  assign o_head = r_mem[r_rd[AW-1:0]];
endmodule

// File: rtl/bank_filter_ctrl.sv
// bank_filter_ctrl: probes both tag banks per queued address, inserts double misses alternately, forwards them
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of bank_filter_ctrl_if (request in, lookup/insert to banks, filtered out, counters)
module bank_filter_ctrl import bank_filter_pkg::*; #(
  parameter int WIDTH = ADDR_WIDTH,
  parameter int DEPTH = 8,
  parameter int CNT_WIDTH = 32
) (
  input logic clk,
  input logic rst,
  bank_filter_ctrl_if.slave bus
);
  state_e r_state, w_next;
  logic r_side;
  logic [WIDTH-1:0] r_miss_addr, w_head;
  logic [CNT_WIDTH-1:0] r_hit_cnt, r_miss_cnt;
  logic w_full, w_empty, w_push, w_lookup, w_hit;
  assign w_push = bus.req_valid_i && !w_full;
  addr_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .i_push(w_push), .i_pop(w_lookup), .i_data(bus.req_addr_i),
    .o_full(w_full), .o_empty(w_empty), .o_head(w_head)
  );
  always_comb begin
    w_hit = bus.left_hit_i || bus.right_hit_i;
    w_lookup = r_state == LOOKUP && !w_empty;
    w_next = r_state == INSERT ? EMIT :
             r_state == EMIT ? (bus.out_ready_i ? LOOKUP : EMIT) :
             (w_lookup && !w_hit ? INSERT : LOOKUP);
    bus.req_ready_o = !w_full;
    bus.lk_read_o = w_lookup;
    bus.lk_addr_o = w_lookup ? w_head : '0;
    // a write overlapping reset is suppressed so the bank never sees a half-abandoned insert
    bus.left_write_o = r_state == INSERT && r_side == SIDE_LEFT && !rst;
    bus.right_write_o = r_state == INSERT && r_side == SIDE_RIGHT && !rst;
    bus.ins_data_o = r_state == INSERT ? r_miss_addr : '0;
    bus.out_valid_o = r_state == EMIT;
    bus.out_addr_o = r_state == EMIT ? r_miss_addr : '0;
    bus.hit_count_o = r_hit_cnt;
    bus.miss_count_o = r_miss_cnt;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= LOOKUP;
      r_side <= SIDE_LEFT;
      r_miss_addr <= '0;
      r_hit_cnt <= '0;
      r_miss_cnt <= '0;
    end else begin
      r_state <= w_next;
      if (w_lookup && w_hit && r_hit_cnt != '1) r_hit_cnt <= r_hit_cnt + 1'b1;
      if (w_lookup && !w_hit) begin
        r_miss_addr <= w_head;
        if (r_miss_cnt != '1) r_miss_cnt <= r_miss_cnt + 1'b1;
      end
      if (r_state == INSERT) r_side <= ~r_side;
    end
  end
endmodule

// File: tb/tb_bank_filter_ctrl.sv
// tb_bank_filter_ctrl: directed self-checking bench for bank_filter_ctrl (CNT_WIDTH=4 build)
module tb_bank_filter_ctrl;
  localparam int W = 64;
  localparam int CW = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_checks = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  bank_filter_ctrl_if #(.WIDTH(W), .CNT_WIDTH(CW)) bus ();
  bank_filter_ctrl #(.WIDTH(W), .DEPTH(8), .CNT_WIDTH(CW)) dut (.clk(clk), .rst(rst), .bus(bus));

  task automatic idle();
    bus.req_valid_i = 1'b0;
    bus.req_addr_i = '0;
    bus.left_hit_i = 1'b0;
    bus.right_hit_i = 1'b0;
    bus.out_ready_i = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (bus.req_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready got %b exp 1", bus.req_ready_o); end
    n_checks++; if (bus.lk_read_o !== 1'b0) begin n_fail++; $display("FAIL reset_lk_read got %b exp 0", bus.lk_read_o); end
    n_checks++; if (bus.lk_addr_o !== 64'h0) begin n_fail++; $display("FAIL reset_lk_addr got %h exp 0", bus.lk_addr_o); end
    n_checks++; if ({bus.left_write_o, bus.right_write_o} !== 2'b00) begin n_fail++; $display("FAIL reset_writes got %b exp 00", {bus.left_write_o, bus.right_write_o}); end
    n_checks++; if (bus.out_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b exp 0", bus.out_valid_o); end
    n_checks++; if (bus.out_addr_o !== 64'h0) begin n_fail++; $display("FAIL reset_out_addr got %h exp 0", bus.out_addr_o); end
    n_checks++; if (bus.ins_data_o !== 64'h0) begin n_fail++; $display("FAIL reset_ins_data got %h exp 0", bus.ins_data_o); end
    n_checks++; if (bus.hit_count_o !== 4'd0) begin n_fail++; $display("FAIL reset_hit_count got %0d exp 0", bus.hit_count_o); end
    n_checks++; if (bus.miss_count_o !== 4'd0) begin n_fail++; $display("FAIL reset_miss_count got %0d exp 0", bus.miss_count_o); end
  endtask

  task automatic test_miss();
    @(negedge clk); bus.req_valid_i = 1'b1; bus.req_addr_i = 64'h1234;
    @(negedge clk); bus.req_valid_i = 1'b0; #1;
    n_checks++; if (bus.lk_read_o !== 1'b1) begin n_fail++; $display("FAIL miss_lk_read got %b exp 1", bus.lk_read_o); end
    n_checks++; if (bus.lk_addr_o !== 64'h1234) begin n_fail++; $display("FAIL miss_lk_addr got %h exp 1234", bus.lk_addr_o); end
    @(negedge clk); #1;
    n_checks++; if ({bus.left_write_o, bus.right_write_o} !== 2'b10) begin n_fail++; $display("FAIL miss_write got %b exp 10", {bus.left_write_o, bus.right_write_o}); end
    n_checks++; if (bus.ins_data_o !== 64'h1234) begin n_fail++; $display("FAIL miss_ins_data got %h exp 1234", bus.ins_data_o); end
    n_checks++; if (bus.lk_read_o !== 1'b0) begin n_fail++; $display("FAIL miss_no_lookup_in_insert got %b exp 0", bus.lk_read_o); end
    @(negedge clk); #1;
    n_checks++; if (bus.out_valid_o !== 1'b1) begin n_fail++; $display("FAIL miss_out_valid got %b exp 1", bus.out_valid_o); end
    n_checks++; if (bus.out_addr_o !== 64'h1234) begin n_fail++; $display("FAIL miss_out_addr got %h exp 1234", bus.out_addr_o); end
    n_checks++; if (bus.ins_data_o !== 64'h0) begin n_fail++; $display("FAIL miss_ins_data_emit got %h exp 0", bus.ins_data_o); end
    n_checks++; if (bus.miss_count_o !== 4'd1) begin n_fail++; $display("FAIL miss_count got %0d exp 1", bus.miss_count_o); end
    bus.out_ready_i = 1'b1;
    @(negedge clk); bus.out_ready_i = 1'b0; #1;
    n_checks++; if (bus.out_valid_o !== 1'b0) begin n_fail++; $display("FAIL miss_out_valid_after got %b exp 0", bus.out_valid_o); end
  endtask

  task automatic test_hit();
    @(negedge clk); bus.req_valid_i = 1'b1; bus.req_addr_i = 64'hABCD;
    @(negedge clk); bus.req_valid_i = 1'b0; bus.right_hit_i = 1'b1; #1;
    n_checks++; if (bus.lk_read_o !== 1'b1 || bus.lk_addr_o !== 64'hABCD) begin n_fail++; $display("FAIL hit_lookup got %b/%h exp 1/abcd", bus.lk_read_o, bus.lk_addr_o); end
    @(negedge clk); bus.right_hit_i = 1'b0; #1;
    n_checks++; if (bus.lk_read_o !== 1'b0) begin n_fail++; $display("FAIL hit_popped got lk_read %b exp 0", bus.lk_read_o); end
    n_checks++; if ({bus.left_write_o, bus.right_write_o} !== 2'b00) begin n_fail++; $display("FAIL hit_no_write got %b exp 00", {bus.left_write_o, bus.right_write_o}); end
    n_checks++; if (bus.out_valid_o !== 1'b0) begin n_fail++; $display("FAIL hit_out_valid got %b exp 0", bus.out_valid_o); end
    n_checks++; if (bus.hit_count_o !== 4'd1) begin n_fail++; $display("FAIL hit_count got %0d exp 1", bus.hit_count_o); end
  endtask

  task automatic test_back_to_back();
    logic [63:0] exp_addr [3];
    logic exp_side [3];
    logic [63:0] wr_addr [4];
    logic wr_side [4];
    logic [63:0] out_addr [4];
    int n_wr = 0;
    int n_out = 0;
    exp_addr[0] = 64'h10; exp_addr[1] = 64'h20; exp_addr[2] = 64'h30;
    exp_side[0] = 1'b0; exp_side[1] = 1'b1; exp_side[2] = 1'b0;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      bus.out_ready_i = 1'b1;
      bus.req_valid_i = i < 3;
      bus.req_addr_i = i < 3 ? exp_addr[i] : 64'h0;
      #1;
      if ((bus.left_write_o || bus.right_write_o) && n_wr < 4) begin
        wr_side[n_wr] = bus.right_write_o;
        wr_addr[n_wr] = bus.ins_data_o;
        n_wr++;
      end
      if (bus.out_valid_o && n_out < 4) begin
        out_addr[n_out] = bus.out_addr_o;
        n_out++;
      end
    end
    bus.out_ready_i = 1'b0;
    n_checks++; if (n_wr != 3) begin n_fail++; $display("FAIL b2b_write_count got %0d exp 3", n_wr); end
    n_checks++; if (n_out != 3) begin n_fail++; $display("FAIL b2b_out_count got %0d exp 3", n_out); end
    for (int i = 0; i < 3; i++) begin
      if (i < n_wr) begin
        n_checks++; if (wr_side[i] !== exp_side[i] || wr_addr[i] !== exp_addr[i]) begin n_fail++; $display("FAIL b2b_write%0d got side %b addr %h exp side %b addr %h", i, wr_side[i], wr_addr[i], exp_side[i], exp_addr[i]); end
      end
      if (i < n_out) begin
        n_checks++; if (out_addr[i] !== exp_addr[i]) begin n_fail++; $display("FAIL b2b_out%0d got %h exp %h", i, out_addr[i], exp_addr[i]); end
      end
    end
    n_checks++; if (bus.miss_count_o !== 4'd3) begin n_fail++; $display("FAIL b2b_miss_count got %0d exp 3", bus.miss_count_o); end
  endtask

  task automatic test_backpressure();
    int n_acc = 0;
    int n_out = 0;
    logic [63:0] outs [12];
    @(negedge clk); bus.req_valid_i = 1'b1; bus.req_addr_i = 64'h500;
    @(negedge clk); bus.req_valid_i = 1'b0; #1;
    n_checks++; if (bus.lk_read_o !== 1'b1) begin n_fail++; $display("FAIL bp_lookup got %b exp 1", bus.lk_read_o); end
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus.req_valid_i = 1'b1;
      bus.req_addr_i = 64'h600 + 64'(n_acc);
      #1;
      n_checks++; if (bus.out_valid_o !== 1'b1 || bus.out_addr_o !== 64'h500) begin n_fail++; $display("FAIL bp_hold%0d got %b/%h exp 1/500", i, bus.out_valid_o, bus.out_addr_o); end
      n_checks++; if (bus.lk_read_o !== 1'b0) begin n_fail++; $display("FAIL bp_no_lookup%0d got %b exp 0", i, bus.lk_read_o); end
      if (bus.req_ready_o) n_acc++;
    end
    n_checks++; if (n_acc != 8) begin n_fail++; $display("FAIL bp_accepts got %0d exp 8", n_acc); end
    n_checks++; if (bus.req_ready_o !== 1'b0) begin n_fail++; $display("FAIL bp_full_ready got %b exp 0", bus.req_ready_o); end
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      bus.req_valid_i = 1'b0;
      bus.out_ready_i = 1'b1;
      #1;
      if (bus.out_valid_o && n_out < 12) begin
        outs[n_out] = bus.out_addr_o;
        n_out++;
      end
    end
    bus.out_ready_i = 1'b0;
    n_checks++; if (n_out != 9) begin n_fail++; $display("FAIL bp_drain_count got %0d exp 9", n_out); end
    for (int i = 0; i < 9; i++) begin
      if (i < n_out) begin
        n_checks++; if (outs[i] !== (i == 0 ? 64'h500 : 64'h600 + 64'(i - 1))) begin n_fail++; $display("FAIL bp_drain%0d got %h", i, outs[i]); end
      end
    end
    n_checks++; if (bus.miss_count_o !== 4'd12) begin n_fail++; $display("FAIL bp_miss_count got %0d exp 12", bus.miss_count_o); end
    n_checks++; if (bus.req_ready_o !== 1'b1) begin n_fail++; $display("FAIL bp_ready_after got %b exp 1", bus.req_ready_o); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); bus.req_valid_i = 1'b1; bus.req_addr_i = 64'h700 + 64'(i);
    end
    @(negedge clk); bus.req_valid_i = 1'b0; #1;
    n_checks++; if (bus.out_valid_o !== 1'b1 || bus.out_addr_o !== 64'h700) begin n_fail++; $display("FAIL rm_in_emit got %b/%h exp 1/700", bus.out_valid_o, bus.out_addr_o); end
    rst = 1'b1;
    @(negedge clk); rst = 1'b0; #1;
    n_checks++; if (bus.out_valid_o !== 1'b0) begin n_fail++; $display("FAIL rm_out_valid got %b exp 0", bus.out_valid_o); end
    n_checks++; if (bus.req_ready_o !== 1'b1) begin n_fail++; $display("FAIL rm_req_ready got %b exp 1", bus.req_ready_o); end
    n_checks++; if (bus.lk_read_o !== 1'b0) begin n_fail++; $display("FAIL rm_lk_read got %b exp 0", bus.lk_read_o); end
    n_checks++; if (bus.hit_count_o !== 4'd0 || bus.miss_count_o !== 4'd0) begin n_fail++; $display("FAIL rm_counters got %0d/%0d exp 0/0", bus.hit_count_o, bus.miss_count_o); end
    bus.req_valid_i = 1'b1; bus.req_addr_i = 64'h800;
    @(negedge clk); bus.req_valid_i = 1'b0; #1;
    n_checks++; if (bus.lk_addr_o !== 64'h800) begin n_fail++; $display("FAIL rm_lookup got %h exp 800", bus.lk_addr_o); end
    @(negedge clk); #1;
    n_checks++; if ({bus.left_write_o, bus.right_write_o} !== 2'b10 || bus.ins_data_o !== 64'h800) begin n_fail++; $display("FAIL rm_left_write got %b/%h exp 10/800", {bus.left_write_o, bus.right_write_o}, bus.ins_data_o); end
    @(negedge clk); bus.out_ready_i = 1'b1;
    @(negedge clk); bus.out_ready_i = 1'b0; bus.req_valid_i = 1'b1; bus.req_addr_i = 64'h900;
    @(negedge clk); bus.req_valid_i = 1'b0;
    @(negedge clk); #1;
    n_checks++; if (bus.right_write_o !== 1'b1) begin n_fail++; $display("FAIL rm_insert_right got %b exp 1", bus.right_write_o); end
    rst = 1'b1; #1;
    n_checks++; if ({bus.left_write_o, bus.right_write_o} !== 2'b00) begin n_fail++; $display("FAIL rm_write_during_rst got %b exp 00", {bus.left_write_o, bus.right_write_o}); end
    @(negedge clk); rst = 1'b0; #1;
  endtask

  task automatic test_saturation();
    do_reset();
    bus.left_hit_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      n_checks++; if (bus.lk_read_o !== 1'b0 || bus.hit_count_o !== 4'd0) begin n_fail++; $display("FAIL sat_empty_hit%0d got %b/%0d exp 0/0", i, bus.lk_read_o, bus.hit_count_o); end
    end
    for (int i = 0; i < 22; i++) begin
      @(negedge clk);
      bus.req_valid_i = i < 20;
      bus.req_addr_i = 64'hC00 + 64'(i);
      #1;
      if (i == 11) begin
        n_checks++; if (bus.hit_count_o !== 4'd10) begin n_fail++; $display("FAIL sat_mid got %0d exp 10", bus.hit_count_o); end
      end
      if (bus.left_write_o || bus.right_write_o || bus.out_valid_o) begin
        n_checks++; n_fail++; $display("FAIL sat_unexpected_insert at %0d got writes %b out_valid %b", i, {bus.left_write_o, bus.right_write_o}, bus.out_valid_o);
      end
    end
    n_checks++; if (bus.hit_count_o !== 4'd15) begin n_fail++; $display("FAIL sat_hold got %0d exp 15", bus.hit_count_o); end
    n_checks++; if (bus.miss_count_o !== 4'd0) begin n_fail++; $display("FAIL sat_miss got %0d exp 0", bus.miss_count_o); end
    n_checks++; if (bus.lk_read_o !== 1'b0) begin n_fail++; $display("FAIL sat_drained got %b exp 0", bus.lk_read_o); end
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_miss();
    test_hit();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/bank_filter_ctrl.md
Name: bank_filter_ctrl

Overview:
Lookup/insert controller that sits directly upstream of the left/right tag-bank pair (SIDE=0 and SIDE=1 instances). It buffers incoming addresses and probes both banks with each one. On a double miss it inserts the address into one bank, alternating sides, and forwards it downstream as a filtered, new-address stream. Hits are dropped; hits and misses are counted for statistics.

Parameters:
WIDTH, 64, address/data width; matches bank WIDTH
DEPTH, 8, input FIFO entries; power of two, >= 2
CNT_WIDTH, 32, width of hit/miss statistic counters

Ports:
clk  in  1  clock
rst  in  1  reset
req_valid_i  in  1  upstream address valid
req_ready_o  out  1  FIFO can accept
req_addr_i  in  WIDTH  upstream address
lk_read_o  out  1  lookup strobe to both banks (bank read_i)
lk_addr_o  out  WIDTH  lookup address to both banks (bank read_address_i)
left_hit_i  in  1  hit_o of SIDE=0 bank
right_hit_i  in  1  hit_o of SIDE=1 bank
left_write_o  out  1  write_i of SIDE=0 bank
right_write_o  out  1  write_i of SIDE=1 bank
ins_data_o  out  WIDTH  data_i to both banks
out_valid_o  out  1  filtered address valid
out_ready_i  in  1  downstream accept
out_addr_o  out  WIDTH  filtered (missed) address
hit_count_o  out  CNT_WIDTH  lookups that hit in either bank
miss_count_o  out  CNT_WIDTH  lookups that missed both banks

Behaviour:
- Reset: rst, synchronous, active-high; clock clk. On rst: FIFO empty, state LOOKUP, side_sel=0 (left), all outputs 0 except req_ready_o=1. Counters 0.
- Reset mid-operation: pending INSERT/EMIT is abandoned and FIFO contents are discarded. A bank write is not issued if rst is high in that cycle.
- FIFO: req_ready_o = !full. Enqueue on req_valid_i && req_ready_o. An enqueued entry is visible to lookup in the following cycle. Pointers are log2(DEPTH)+1 bits, so wrap is handled by the MSB compare.
- FSM states: LOOKUP, INSERT, EMIT.
- LOOKUP: lk_read_o = !empty; lk_addr_o = FIFO head. Bank hit is combinational in the same cycle.
  - Hit (left_hit_i | right_hit_i) with !empty: pop, hit_count++, stay LOOKUP. Back-to-back hits run at 1 per cycle.
  - Miss with !empty: latch head into miss_addr, pop, miss_count++, go INSERT.
  - Empty: stay LOOKUP; hit inputs are ignored.
- INSERT: one cycle. ins_data_o = miss_addr. Assert left_write_o if side_sel=0, else right_write_o; exactly one is high. Toggle side_sel at the end of the cycle, then go EMIT.
- EMIT: out_valid_o=1, out_addr_o=miss_addr, both held stable until out_valid_o && out_ready_i. Then go LOOKUP. No lookup is issued in INSERT/EMIT, but the FIFO keeps accepting.
- Miss latency: lookup in cycle t, bank write in t+1, out_valid_o from t+2. Earliest next lookup is t+3. Because the write completes before the next lookup, there is no read-after-insert hazard.
- Counters saturate at all-ones; no wrap.
- ins_data_o is 0 and write strobes are low outside INSERT. out_addr_o is 0 outside EMIT.

Decomposition:
- Package bank_filter_pkg: state_e enum {LOOKUP, INSERT, EMIT}; shared WIDTH default constant; side encoding constants (SIDE_LEFT=0, SIDE_RIGHT=1), shared with the bank instantiation.
- One sub-module: addr_fifo, a synchronous FIFO (parameters WIDTH, DEPTH) with push/pop/full/empty/head.

Test Plan:
1. Reset, push 0x1234, both hits 0 -> lk_read_o for 1 cycle with lk_addr_o=0x1234; next cycle left_write_o=1 with ins_data_o=0x1234; then out_valid_o=1 with out_addr_o=0x1234; miss_count_o=1.
2. Push 0xABCD with right_hit_i=1 during lookup -> popped in 1 cycle, no write strobe, out_valid_o stays 0, hit_count_o=1.
3. Three back-to-back misses 0x10, 0x20, 0x30, out_ready_i=1 -> writes go left, right, left; outputs appear in order; miss_count_o=3.
4. out_ready_i=0 for 10 cycles after a miss while pushing continuously -> out_valid_o/out_addr_o stable; no lk_read_o; req_ready_o drops after 8 further accepts; drain resumes when out_ready_i=1.
5. Assert rst during EMIT with 4 entries queued -> next cycle out_valid_o=0, req_ready_o=1, lk_read_o=0, counters 0; next miss writes the left bank.
6. Empty FIFO with left_hit_i=1 forced -> lk_read_o=0, hit_count_o unchanged; 2^CNT_WIDTH+ hits (CNT_WIDTH=4 build: 20 hits) -> hit_count_o holds at 15.
